// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: pops one byte from the TX FIFO when idle and frames it
// as start, 8 data bits LSB first, optional parity and 1 or 2 stop bits.
module uart_tx_ctrl #(
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_en,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       sr_empty,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);

    localparam int            BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic          STOP_LAST = (STOP_BITS == 2);
    localparam logic          PAR_INIT  = (PARITY_ODD != 0);
    localparam logic          USE_PAR   = (PARITY_EN != 0);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t        state;
    logic [7:0]    shreg;
    logic [2:0]    bit_cnt;
    logic [BW-1:0] baud_cnt;
    logic          stop_cnt;
    logic          par;
    logic          bit_end;

    // sr_empty is independent of data_valid so the FIFO handshake has no loop.
    always_comb begin
        sr_empty = (state == IDLE) && tx_en;
        busy     = (state != IDLE);
        bit_end  = (baud_cnt == BAUD_LAST);
    end

    // tx is registered, so each transition loads the level of the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            baud_cnt <= '0;
            stop_cnt <= 1'b0;
            par      <= 1'b0;
            tx       <= 1'b1;
            tx_done  <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (state != IDLE) begin
                baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
            end
            case (state)
                IDLE: begin
                    tx       <= 1'b1;
                    stop_cnt <= 1'b0;
                    if (data_valid && sr_empty) begin
                        shreg    <= data_in;
                        par      <= (^data_in) ^ PAR_INIT;
                        baud_cnt <= '0;
                        tx       <= 1'b0;
                        state    <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        tx      <= shreg[0];
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        shreg <= {1'b0, shreg[7:1]};
                        if (bit_cnt == 3'd7) begin
                            if (USE_PAR) begin
                                tx    <= par;
                                state <= PARITY;
                            end else begin
                                stop_cnt <= 1'b0;
                                tx       <= 1'b1;
                                state    <= STOP;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            tx      <= shreg[1];
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        stop_cnt <= 1'b0;
                        tx       <= 1'b1;
                        state    <= STOP;
                    end
                end
                STOP: begin
                    tx <= 1'b1;
                    if (bit_end) begin
                        if (stop_cnt == STOP_LAST) begin
                            tx_done <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            stop_cnt <= 1'b1;
                        end
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: four configurations fed by FIFO models; a monitor checks
// each serial frame against scoreboard entries queued when bytes are pushed.
module tb_uart_tx_ctrl;

    typedef struct {
        int         ch;
        logic [7:0] data;
        logic       par;
        int         len;   // expected frame clocks; 0 means the frame is cut by reset
        bit         b2b;   // start must follow the previous tx_done by one cycle
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx_en = 1'b1;

    logic [3:0] tx_w, busy_w, done_w, sre_w, dv_w;
    logic [7:0] din_w [4];

    logic [7:0] fmem [4][4];
    logic [1:0] wr [4] = '{2'd0, 2'd0, 2'd0, 2'd0};
    logic [1:0] rd [4] = '{2'd0, 2'd0, 2'd0, 2'd0};
    int         fcnt [4] = '{0, 0, 0, 0};
    int         pops [4] = '{0, 0, 0, 0};
    logic       push_req [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
    logic [7:0] push_data [4] = '{8'h00, 8'h00, 8'h00, 8'h00};

    exp_t sbq[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    bit   act [4];
    int   cyc [4];
    int   bad [4];
    int   since [4];
    exp_t cur [4];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_ch
        assign dv_w[g]  = (fcnt[g] != 0) && sre_w[g];
        assign din_w[g] = fmem[g][rd[g]];
        uart_tx_ctrl #(
            .CLKS_PER_BIT(4),
            .PARITY_EN   ((g == 1 || g == 2) ? 1 : 0),
            .PARITY_ODD  ((g == 2) ? 1 : 0),
            .STOP_BITS   ((g == 3) ? 2 : 1)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .tx_en     (tx_en),
            .data_in   (din_w[g]),
            .data_valid(dv_w[g]),
            .sr_empty  (sre_w[g]),
            .tx        (tx_w[g]),
            .busy      (busy_w[g]),
            .tx_done   (done_w[g])
        );
    end

    // 4-deep FIFO model per channel; pops whenever it presents data to a free shifter.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (push_req[i]) begin
                fmem[i][wr[i]] <= push_data[i];
                wr[i] <= wr[i] + 2'd1;
            end
            if (dv_w[i]) begin
                rd[i]   <= rd[i] + 2'd1;
                pops[i] <= pops[i] + 1;
            end
            fcnt[i] <= fcnt[i] + (push_req[i] ? 1 : 0) - (dv_w[i] ? 1 : 0);
        end
    end

    function automatic logic level(input int ch, input exp_t e, input int off);
        int b;
        b = off / 4;
        if (b == 0) return 1'b0;
        if (b <= 8) return e.data[b-1];
        if ((ch == 1 || ch == 2) && b == 9) return e.par;
        return 1'b1;
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic monitor();
        for (int i = 0; i < 4; i++) begin
            act[i] = 1'b0;
            since[i] = 1000;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (since[i] < 1000) since[i]++;
                if (rst) begin
                    if (act[i]) begin
                        chk($sformatf("ch%0d_abort_expected", i), (cur[i].len == 0) ? 1 : 0, 1);
                        act[i] = 1'b0;
                    end
                end else if (!act[i]) begin
                    if (done_w[i]) chk($sformatf("ch%0d_spurious_tx_done", i), 1, 0);
                    if (tx_w[i] == 1'b0) begin
                        if (sbq.size() == 0) begin
                            chk($sformatf("ch%0d_unexpected_frame", i), 1, 0);
                            cur[i] = '{ch: i, data: 8'h00, par: 1'b0, len: -1, b2b: 1'b0};
                        end else begin
                            cur[i] = sbq.pop_front();
                            chk($sformatf("ch%0d_frame_channel", i), i, cur[i].ch);
                            if (cur[i].b2b) chk($sformatf("ch%0d_b2b_gap", i), since[i], 1);
                        end
                        act[i] = 1'b1;
                        cyc[i] = 1;
                        bad[i] = 0;
                    end
                end else if (done_w[i]) begin
                    chk($sformatf("ch%0d_frame_len_%02h", i, cur[i].data), cyc[i], cur[i].len);
                    chk($sformatf("ch%0d_waveform_bad_clocks_%02h", i, cur[i].data), bad[i], 0);
                    act[i] = 1'b0;
                    since[i] = 0;
                end else begin
                    if (tx_w[i] !== level(i, cur[i], cyc[i])) bad[i]++;
                    cyc[i]++;
                    if (cyc[i] > 200) begin
                        chk($sformatf("ch%0d_tx_done_timeout", i), cyc[i], cur[i].len);
                        act[i] = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic push(input int ch, input logic [7:0] d, input logic p, input int len, input bit b2b);
        sbq.push_back('{ch: ch, data: d, par: p, len: len, b2b: b2b});
        @(negedge clk);
        push_req[ch]  = 1'b1;
        push_data[ch] = d;
        @(negedge clk);
        push_req[ch]  = 1'b0;
    endtask

    task automatic wait_idle(input int ch, input int maxc);
        int n;
        n = 0;
        while (!(fcnt[ch] == 0 && busy_w[ch] == 1'b0 && push_req[ch] == 1'b0) && n < maxc) begin
            @(negedge clk);
            n++;
        end
        if (n >= maxc) chk($sformatf("ch%0d_wait_idle_timeout", ch), n, 0);
    endtask

    task automatic wait_busy(input int ch, input int maxc);
        int n;
        n = 0;
        while (busy_w[ch] == 1'b0 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        if (n >= maxc) chk($sformatf("ch%0d_wait_busy_timeout", ch), n, 0);
    endtask

    initial begin
        int p0;
        fork
            monitor();
        join_none

        // Reset held three cycles with tx_en high
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("ch%0d_rst_tx", i), int'(tx_w[i]), 1);
            chk($sformatf("ch%0d_rst_busy", i), int'(busy_w[i]), 0);
            chk($sformatf("ch%0d_rst_tx_done", i), int'(done_w[i]), 0);
            chk($sformatf("ch%0d_rst_sr_empty", i), int'(sre_w[i]), 1);
        end
        rst = 1'b0;
        @(negedge clk);

        // Single frame 0xA5, 40 clocks
        p0 = pops[0];
        push(0, 8'hA5, 1'b0, 40, 1'b0);
        wait_idle(0, 100);
        chk("single_pop_count", pops[0] - p0, 1);

        // Parity: 0x07 even -> 1, odd -> 0, 44 clocks
        push(1, 8'h07, 1'b1, 44, 1'b0);
        wait_idle(1, 100);
        push(2, 8'h07, 1'b0, 44, 1'b0);
        wait_idle(2, 100);

        // Two stop bits: 0xFF, 44 clocks
        push(3, 8'hFF, 1'b0, 44, 1'b0);
        wait_idle(3, 100);

        // Back-to-back with a full FIFO
        tx_en = 1'b0;
        push(0, 8'h11, 1'b0, 40, 1'b0);
        push(0, 8'h22, 1'b0, 40, 1'b1);
        push(0, 8'h33, 1'b0, 40, 1'b1);
        push(0, 8'h44, 1'b0, 40, 1'b1);
        chk("b2b_fifo_full", fcnt[0], 4);
        tx_en = 1'b1;
        wait_idle(0, 400);
        chk("b2b_fifo_drained", fcnt[0], 0);
        repeat (5) @(negedge clk);
        chk("b2b_idle_sr_empty", int'(sre_w[0]), 1);
        chk("b2b_idle_tx", int'(tx_w[0]), 1);

        // Enable gating with two bytes queued
        tx_en = 1'b0;
        push(0, 8'h55, 1'b0, 40, 1'b0);
        push(0, 8'h66, 1'b0, 40, 1'b0);
        repeat (20) @(negedge clk);
        chk("gate_sr_empty", int'(sre_w[0]), 0);
        chk("gate_tx", int'(tx_w[0]), 1);
        chk("gate_fifo_count", fcnt[0], 2);
        chk("gate_busy", int'(busy_w[0]), 0);
        tx_en = 1'b1;
        wait_busy(0, 10);
        repeat (10) @(negedge clk);
        tx_en = 1'b0;
        begin
            int n;
            n = 0;
            while (busy_w[0] && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (n >= 100) chk("gate_frame_end_timeout", n, 0);
        end
        repeat (10) @(negedge clk);
        chk("gate_mid_sr_empty", int'(sre_w[0]), 0);
        chk("gate_mid_fifo_count", fcnt[0], 1);
        chk("gate_mid_busy", int'(busy_w[0]), 0);
        tx_en = 1'b1;
        wait_idle(0, 100);

        // Asynchronous reset in the middle of the data bits
        push(0, 8'h3C, 1'b0, 0, 1'b0);
        wait_busy(0, 10);
        repeat (8) @(negedge clk);
        chk("pre_rst_tx_bit1", int'(tx_w[0]), 0);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_tx", int'(tx_w[0]), 1);
        chk("async_rst_busy", int'(busy_w[0]), 0);
        chk("async_rst_tx_done", int'(done_w[0]), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst_fifo_count", fcnt[0], 0);
        chk("post_rst_sr_empty", int'(sre_w[0]), 1);

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
